// File: rtl/jt1943_rom_arb_if.sv
// Bus bundle for the 4-client SDRAM ROM read arbiter: client requests/addresses,
// shared data return and the SDRAM controller handshake.
interface jt1943_rom_arb_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  logic              downloading;
  logic [3:0]        req;
  logic [4*AW-1:0]   addr;
  logic [DW-1:0]     dout;
  logic [3:0]        ok;
  logic              sdram_req;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_ack;
  logic              data_rdy;
  logic [DW-1:0]     data_read;
  logic              busy;
  logic              tout_err;

  modport slave (
    input  downloading, req, addr, sdram_ack, data_rdy, data_read,
    output dout, ok, sdram_req, sdram_addr, busy, tout_err
  );

  modport master (
    output downloading, req, addr, sdram_ack, data_rdy, data_read,
    input  dout, ok, sdram_req, sdram_addr, busy, tout_err
  );
endinterface

// File: rtl/jt1943_rom_arb.sv
// 4-client SDRAM ROM read arbiter with WAIT watchdog. Fixed priority by default;
// define JT1943_ROM_ARB_RR_EN for round-robin arbitration.
module jt1943_rom_arb #(
  parameter int AW   = 22,
  parameter int DW   = 32,
  parameter int TOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  jt1943_rom_arb_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;

  st_t             r_st, w_st_nxt;
  logic [1:0]      r_gnt, w_gnt_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_dout, w_dout_nxt;
  logic [3:0]      r_ok, w_ok_nxt;
  logic            r_sreq, w_sreq_nxt;
  logic            r_terr, w_terr_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [7:0]      w_cnt_inc;
  logic [3:0]      w_cand;
  logic            w_any;
  logic [1:0]      w_win;

  // A client whose ok is pulsing this cycle is still holding req; skip it once.
  assign w_cand    = bus.req & ~r_ok;
  assign w_cnt_inc = r_cnt + 8'd1;

`ifdef JT1943_ROM_ARB_RR_EN
  logic [1:0] r_ptr;
  logic [1:0] w_idx;

  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_any && w_cand[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= 2'd3;
    else if (r_st == IDLE && !bus.downloading && w_any)
      r_ptr <= w_win;
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_any && w_cand[k]) begin
        w_any = 1'b1;
        w_win = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    w_st_nxt   = r_st;
    w_gnt_nxt  = r_gnt;
    w_addr_nxt = r_addr;
    w_dout_nxt = r_dout;
    w_ok_nxt   = '0;
    w_sreq_nxt = r_sreq;
    w_terr_nxt = r_terr;
    w_cnt_nxt  = r_cnt;
    case (r_st)
      IDLE: begin
        if (!bus.downloading && w_any) begin
          w_st_nxt   = REQ;
          w_sreq_nxt = 1'b1;
          w_gnt_nxt  = w_win;
          w_addr_nxt = bus.addr[32'(w_win)*AW +: AW];
        end
      end
      REQ: begin
        if (bus.downloading) begin
          w_st_nxt   = IDLE;
          w_sreq_nxt = 1'b0;
        end else if (bus.sdram_ack) begin
          w_sreq_nxt = 1'b0;
          if (bus.data_rdy) begin
            w_st_nxt   = IDLE;
            w_dout_nxt = bus.data_read;
            w_ok_nxt   = 4'b0001 << r_gnt;
          end else begin
            w_st_nxt  = WAIT;
            w_cnt_nxt = '0;
          end
        end
      end
      WAIT: begin
        if (bus.downloading) begin
          w_st_nxt = IDLE;
        end else if (bus.data_rdy) begin
          w_st_nxt   = IDLE;
          w_dout_nxt = bus.data_read;
          w_ok_nxt   = 4'b0001 << r_gnt;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == 8'(TOUT)) begin
            w_st_nxt   = IDLE;
            w_terr_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_st_nxt   = IDLE;
        w_sreq_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= IDLE;
      r_gnt  <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_ok   <= '0;
      r_sreq <= 1'b0;
      r_terr <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_gnt  <= w_gnt_nxt;
      r_addr <= w_addr_nxt;
      r_dout <= w_dout_nxt;
      r_ok   <= w_ok_nxt;
      r_sreq <= w_sreq_nxt;
      r_terr <= w_terr_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.ok         = r_ok;
  assign bus.sdram_req  = r_sreq;
  assign bus.sdram_addr = r_addr;
  assign bus.busy       = (r_st != IDLE);
  assign bus.tout_err   = r_terr;

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Randomized transaction-level bench for jt1943_rom_arb against a grant/data model.
module tb_jt1943_rom_arb;
  localparam int AW   = 22;
  localparam int DW   = 32;
  localparam int TOUT = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jt1943_rom_arb_if #(.AW(AW), .DW(DW)) bus ();
  jt1943_rom_arb #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = 3;
  int m_okg = -1;
  logic [DW-1:0] m_dout = '0;
  logic          m_terr = 1'b0;
  logic [AW-1:0] m_addr [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] v);
`ifdef JT1943_ROM_ARB_RR_EN
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (v[c]) return c;
    end
`else
    for (int c = 0; c < 4; c++) if (v[c]) return c;
`endif
    return -1;
  endfunction

  task automatic set_addrs;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = AW'($urandom);
      bus.addr[i*AW +: AW] = m_addr[i];
    end
  endtask

  task automatic gap(input int n);
    bus.req = '0;
    m_okg = -1;
    repeat (n) begin
      bus.data_rdy  = 1'($urandom);
      bus.data_read = $urandom;
      step;
      check("gap_ok", bus.ok, 0);
      check("gap_dout", bus.dout, m_dout);
      check("gap_busy", bus.busy, 0);
    end
    bus.data_rdy = 1'b0;
  endtask

  // mode: 0 normal, 1 watchdog expiry, 2 download in REQ, 3 download in WAIT, 4 reset in WAIT
  task automatic xfer(input logic [3:0] reqv, input int ack_dly, input int rdy_dly,
                      input logic [DW-1:0] data, input int mode, input bit scramble,
                      output int g_obs);
    logic [3:0]    v;
    logic [AW-1:0] ea;
    int exp_g, lat, n;
    v = reqv;
    if (m_okg >= 0) v[m_okg] = 1'b0;
    exp_g = pick(v);
    lat = 1;
    if (exp_g < 0) begin
      exp_g = pick(reqv);
      lat = 2;
    end
    ea = m_addr[exp_g];
    bus.req = reqv;
    m_okg = -1;
    g_obs = -1;
    n = 0;
    do begin
      step;
      n++;
      check("ok_idle", bus.ok, 0);
    end while (!bus.sdram_req && n < 4);
    check("grant_lat", n, lat);
    check("sdram_addr", bus.sdram_addr, ea);
    check("busy_req", bus.busy, 1);
    m_ptr = exp_g;
    if (scramble) begin
      set_addrs;
      bus.req = 4'($urandom);
    end
    if (mode == 2) begin
      bus.downloading = 1'b1;
      bus.req = 4'hF;
      repeat (3) begin
        step;
        check("dl_sreq", bus.sdram_req, 0);
        check("dl_busy", bus.busy, 0);
        check("dl_ok", bus.ok, 0);
      end
      bus.downloading = 1'b0;
      return;
    end
    repeat (ack_dly) begin
      step;
      check("hold_sreq", bus.sdram_req, 1);
      check("hold_addr", bus.sdram_addr, ea);
    end
    bus.sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      bus.data_rdy  = 1'b1;
      bus.data_read = data;
    end
    step;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    check("ack_drop", bus.sdram_req, 0);
    if (rdy_dly > 0) begin
      if (mode == 1) begin
        repeat (TOUT - 1) begin
          check("wd_busy", bus.busy, 1);
          check("wd_ok", bus.ok, 0);
          step;
        end
        check("wd_last", bus.busy, 1);
        step;
        m_terr = 1'b1;
        check("wd_idle", bus.busy, 0);
        check("wd_terr", bus.tout_err, 1);
        check("wd_nook", bus.ok, 0);
        return;
      end
      if (mode == 3) begin
        bus.downloading = 1'b1;
        step;
        check("dlw_busy", bus.busy, 0);
        bus.data_rdy = 1'b1;
        bus.data_read = data;
        step;
        check("dlw_ok", bus.ok, 0);
        check("dlw_dout", bus.dout, m_dout);
        bus.data_rdy = 1'b0;
        bus.downloading = 1'b0;
        return;
      end
      if (mode == 4) begin
        #2 rst = 1'b1;
        #1;
        check("rst_ok", bus.ok, 0);
        check("rst_sreq", bus.sdram_req, 0);
        check("rst_saddr", bus.sdram_addr, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_terr", bus.tout_err, 0);
        m_dout = '0; m_terr = 1'b0; m_ptr = 3;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req = '0;
        bus.data_rdy = 1'b1;
        bus.data_read = data;
        step;
        check("rst_late_ok", bus.ok, 0);
        check("rst_late_dout", bus.dout, 0);
        bus.data_rdy = 1'b0;
        return;
      end
      repeat (rdy_dly - 1) begin
        step;
        check("ok_early", bus.ok, 0);
      end
      bus.data_rdy  = 1'b1;
      bus.data_read = data;
      step;
      bus.data_rdy  = 1'b0;
    end
    bus.data_read = $urandom;
    check("ok_pulse", bus.ok, 4'b0001 << exp_g);
    check("dout", bus.dout, data);
    check("terr_sticky", bus.tout_err, m_terr);
    for (int i = 0; i < 4; i++) if (bus.ok[i]) g_obs = i;
    m_dout = data;
    m_okg = exp_g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    int g, r, md;
    rst = 1'b1;
    bus.downloading = 1'b0;
    bus.req = '0;
    bus.addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    bus.data_read = '0;
    repeat (2) @(posedge clk);
    #1;
    check("r_ok", bus.ok, 0);
    check("r_sreq", bus.sdram_req, 0);
    check("r_saddr", bus.sdram_addr, 0);
    check("r_dout", bus.dout, 0);
    check("r_busy", bus.busy, 0);
    check("r_terr", bus.tout_err, 0);
    rst = 1'b0;
    step;

    set_addrs;
    m_addr[0] = 22'h00123;
    bus.addr[0 +: AW] = m_addr[0];
    xfer(4'b0001, 2, 3, 32'hDEADBEEF, 0, 0, g);
    check("basic_g", g, 0);
    gap(2);

    set_addrs;
    for (int i = 0; i < 8; i++) begin
      xfer(4'hF, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 0, 0, g);
`ifdef JT1943_ROM_ARB_RR_EN
      check("seq_rr", g, i % 4);
`else
      check("seq_fix", g, i % 2);
`endif
    end
    gap(2);

    xfer(4'b0100, 1, 1, $urandom, 1, 0, g);
    xfer(4'b0100, 0, 2, $urandom, 0, 0, g);
    check("after_wd_g", g, 2);

    xfer(4'b0010, 2, 1, $urandom, 2, 0, g);
    xfer(4'b0010, 1, 1, $urandom, 0, 0, g);
    check("after_dl_g", g, 1);

    xfer(4'b1000, 1, 2, $urandom, 4, 0, g);
    xfer(4'b1000, 0, 1, $urandom, 0, 0, g);
    check("after_rst_g", g, 3);

    repeat (60) begin
      r = $urandom_range(0, 9);
      md = 0;
      if (r == 0) md = 3;
      else if (r == 1) md = 1;
      else if (r == 2) md = 2;
      else if (r == 3) gap($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) set_addrs;
      xfer(4'($urandom_range(1, 15)), $urandom_range(0, 3),
           (md == 1 || md == 3) ? $urandom_range(1, 4) : $urandom_range(0, 4),
           $urandom, md, 1'($urandom), g);
    end
    gap(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/jt1943_rom_arb.md
JT1943_ROM_ARB -- requirements
Module: jt1943_rom_arb

Interface
REQ-001 Parameter AW, default 22, SDRAM word-address width.
REQ-002 Parameter DW, default 32, SDRAM read-data width.
REQ-003 Parameter TOUT, default 255, WAIT-state watchdog limit in clk cycles (1..255).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 downloading  input  1  ROM download in progress; blocks and aborts arbitration.
REQ-007 req  input  4  per-client read request, held high until matching ok pulse.
REQ-008 addr  input  4*AW  client addresses, client n at bits [n*AW +: AW].
REQ-009 dout  output  DW  last returned data word, shared by all clients.
REQ-010 ok  output  4  one-cycle data-valid pulse, one-hot, for the granted client.
REQ-011 sdram_req  output  1  read request to the SDRAM controller.
REQ-012 sdram_addr  output  AW  latched address of the granted client.
REQ-013 sdram_ack  input  1  SDRAM controller accepted the request.
REQ-014 data_rdy  input  1  data_read is valid this cycle.
REQ-015 data_read  input  DW  SDRAM read data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 tout_err  output  1  sticky flag, set on watchdog expiry.

Function
REQ-018 FSM states are IDLE, REQ and WAIT, with all outputs registered.
REQ-019 IDLE: if downloading is low and any unmasked req is high, the block latches the winner index and its addr, then enters REQ with sdram_req=1 on the next edge (1-cycle latency).
REQ-020 Mask: in the IDLE cycle coinciding with ok[g], client g is excluded from arbitration.
REQ-021 REQ: the block holds sdram_req and sdram_addr stable until sdram_ack; on sdram_ack it drops sdram_req and enters WAIT.
REQ-022 REQ: if sdram_ack and data_rdy occur in the same cycle, the block completes the transfer as in REQ-023 and enters IDLE.
REQ-023 WAIT: on data_rdy the block sets dout=data_read, sets ok[g]=1 for exactly one cycle, and enters IDLE.
REQ-024 data_rdy while in IDLE is ignored; dout and ok do not change.
REQ-025 A client dropping req or changing addr mid-transaction does not affect the transfer; the latched addr is used and ok still pulses.
REQ-026 WAIT watchdog: an 8-bit counter clears on WAIT entry; when it reaches TOUT the block enters IDLE, sets tout_err, and issues no ok pulse.
REQ-027 downloading high in REQ or WAIT forces IDLE on the next edge, with sdram_req=0 and no ok pulse.
REQ-028 dout holds its value between transfers.

Reset
REQ-029 rst forces IDLE with sdram_req=0, sdram_addr=0, dout=0, ok=0, busy=0, tout_err=0, watchdog=0 and grant pointer=3, whether or not a transfer is in progress.
REQ-030 tout_err is cleared only by rst.

Configuration
REQ-031 Macro JT1943_ROM_ARB_RR_EN.
REQ-032 With JT1943_ROM_ARB_RR_EN defined, arbitration is round-robin: the search starts at last grant+1 modulo 4, and the pointer updates on each grant.
REQ-033 Without JT1943_ROM_ARB_RR_EN, arbitration is fixed priority: client 0 highest, client 3 lowest, and no pointer is implemented.

Verification
REQ-034 req=4'b0001, addr0=0x00123, sdram_ack 2 cycles after sdram_req, data_rdy 3 cycles later with 0xDEADBEEF -> sdram_addr=0x00123, then dout=0xDEADBEEF and ok=4'b0001 for 1 cycle.
REQ-035 req=4'b1111 held, 8 transfers -> fixed priority: grants 0,1,0,1,...; with JT1943_ROM_ARB_RR_EN: grants 0,1,2,3,0,1,2,3.
REQ-036 In WAIT, hold data_rdy low for TOUT cycles -> IDLE, tout_err=1, ok stays 0; the next request then completes normally.
REQ-037 downloading raised while in REQ -> sdram_req=0 next cycle, no ok pulse; requests are ignored until downloading falls, then arbitration resumes.
REQ-038 rst asserted while in WAIT -> all outputs 0 immediately; a data_rdy arriving after rst release produces no ok pulse.
